// File: rtl/simple_bus_arbiter_if.sv
// Requester-side and target-side simple_bus signals of the round-robin arbiter.
interface simple_bus_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]    m_valid;
  logic [NUM_REQ-1:0]    m_we;
  logic [NUM_REQ*32-1:0] m_addr;
  logic [NUM_REQ*32-1:0] m_wdata;
  logic [NUM_REQ-1:0]    m_ready;
  logic [31:0]           m_rdata;

  logic                  s_valid;
  logic                  s_we;
  logic [31:0]           s_addr;
  logic [31:0]           s_wdata;
  logic                  s_ready;
  logic [31:0]           s_rdata;

  logic                  grant_valid;
  logic [IDW-1:0]        grant_id;

  // Arbiter view: consumes requests and target responses.
  modport slave (
    input  m_valid, m_we, m_addr, m_wdata, s_ready, s_rdata,
    output m_ready, m_rdata, s_valid, s_we, s_addr, s_wdata,
           grant_valid, grant_id
  );

  // Environment view: requesters plus the shared target.
  modport master (
    output m_valid, m_we, m_addr, m_wdata, s_ready, s_rdata,
    input  m_ready, m_rdata, s_valid, s_we, s_addr, s_wdata,
           grant_valid, grant_id
  );
endinterface

// File: rtl/simple_bus_arbiter.sv
// Round-robin arbiter sharing one simple_bus target between NUM_REQ requesters.
// Latency: request seen in IDLE -> s_valid next cycle; one transfer per 2 cycles at best.
// Backpressure: s_ready passes straight to the granted requester's m_ready; others wait.
module simple_bus_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  simple_bus_arbiter_if.slave  bus
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]         state;
  logic [IDW-1:0]     grant_id_q;
  logic [IDW-1:0]     last_grant;

  logic               any_req;
  logic               found_hi;
  logic [IDW-1:0]     hi_id;
  logic [IDW-1:0]     lo_id;
  logic [IDW-1:0]     next_id;

  logic               in_grant;
  logic               sel_valid;
  logic               sel_we;
  logic [31:0]        sel_addr;
  logic [31:0]        sel_wdata;
  logic               xfer_done;
  logic [NUM_REQ-1:0] m_ready_d;

  // Lowest requester above last_grant wins; if none, wrap to the lowest requester overall.
  always_comb begin
    any_req  = 1'b0;
    found_hi = 1'b0;
    hi_id    = '0;
    lo_id    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.m_valid[i]) begin
        any_req = 1'b1;
        lo_id   = IDW'(i);
        if (IDW'(i) > last_grant) begin
          found_hi = 1'b1;
          hi_id    = IDW'(i);
        end
      end
    end
    next_id = found_hi ? hi_id : lo_id;
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id_q == IDW'(i)) begin
        sel_valid = bus.m_valid[i];
        sel_we    = bus.m_we[i];
        sel_addr  = bus.m_addr[32*i +: 32];
        sel_wdata = bus.m_wdata[32*i +: 32];
      end
    end
  end

  assign in_grant  = (state == GRANT);
  assign xfer_done = in_grant && sel_valid && bus.s_ready;

  always_comb begin
    m_ready_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (xfer_done && (grant_id_q == IDW'(i))) m_ready_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      grant_id_q <= '0;
      last_grant <= IDW'(NUM_REQ - 1);
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant_id_q <= next_id;
            state      <= GRANT;
          end
        end
        GRANT: begin
          if (xfer_done) begin
            last_grant <= grant_id_q;
            state      <= IDLE;
          end else if (!sel_valid) begin
            // Requester withdrew without completing: drop the grant, keep priority.
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.s_valid     = in_grant && sel_valid;
  assign bus.s_we        = in_grant && sel_we;
  assign bus.s_addr      = in_grant ? sel_addr  : 32'h0;
  assign bus.s_wdata     = in_grant ? sel_wdata : 32'h0;
  assign bus.m_ready     = m_ready_d;
  assign bus.m_rdata     = bus.s_rdata;
  assign bus.grant_valid = in_grant;
  assign bus.grant_id    = grant_id_q;

endmodule

// File: doc/simple_bus_arbiter.md
Name: simple_bus_arbiter

Overview:
- Round-robin arbiter that shares one simple_bus target (valid/ready/we/addr/wdata/rdata) between NUM_REQ requesters.
- Sits between N requester-side simple_bus ports (flattened) and a single target-side port that feeds the DUT.
- Grants one complete transfer per arbitration and forwards the handshake combinationally while granted.
- Guarantees fairness: no requester waits more than NUM_REQ-1 transfers of other requesters.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..16.
- IDW, $clog2(NUM_REQ), width of grant index.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- m_valid  input  NUM_REQ  per-requester request valid.
- m_we  input  NUM_REQ  per-requester write enable (1=write, 0=read).
- m_addr  input  NUM_REQ*32  requester i address at [32*i +: 32].
- m_wdata  input  NUM_REQ*32  requester i write data at [32*i +: 32].
- m_ready  output  NUM_REQ  per-requester completion; one-hot or zero.
- m_rdata  output  32  read data, broadcast to all requesters; qualified by m_ready[i].
- s_valid  output  1  target request valid.
- s_we  output  1  target write enable.
- s_addr  output  32  target address.
- s_wdata  output  32  target write data.
- s_ready  input  1  target completion.
- s_rdata  input  32  target read data; valid in the s_valid && s_ready cycle.
- grant_valid  output  1  high in GRANT state.
- grant_id  output  IDW  index of the current or last granted requester.

Behaviour:
- Transfer definition: a transfer completes in the cycle valid && ready. Requesters hold valid, we, addr and wdata stable until they see ready.
- State machine has two states, IDLE and GRANT.
- IDLE:
  - If any m_valid is high, select the first requester with m_valid high, searching from (last_grant+1) mod NUM_REQ upward with wrap-around.
  - Register that index into grant_id and go to GRANT at the next edge.
  - If no m_valid is high, stay in IDLE.
- GRANT:
  - s_valid = m_valid[grant_id]; s_we, s_addr and s_wdata are muxed from requester grant_id.
  - m_ready[grant_id] = s_ready && s_valid; all other m_ready bits are 0.
  - m_rdata = s_rdata at all times.
- Completion: when s_valid && s_ready, set last_grant = grant_id and return to IDLE at the next edge.
- Abandoned request: if m_valid[grant_id] drops in GRANT without completing (a protocol violation), return to IDLE with no transfer and leave last_grant unchanged.
- Latency and throughput:
  - Request sampled in IDLE at cycle 0; s_valid is asserted in cycle 1.
  - With zero-wait target (s_ready tied high), a transfer completes in cycle 1.
  - Peak throughput is one transfer per 2 cycles.
- Outputs in IDLE: s_valid=0 and m_ready=0; s_we, s_addr and s_wdata are 0.
- Non-granted requesters: requests arriving in GRANT are ignored until the next IDLE. m_valid changes from non-granted requesters never affect the s_* outputs.
- Reset (asynchronous, any time, including mid-transfer):
  - State goes to IDLE; grant_valid=0; grant_id=0.
  - last_grant = NUM_REQ-1, so requester 0 has top priority after reset.
  - All m_ready=0, s_valid=0, s_we=0, s_addr=0, s_wdata=0.
  - An in-flight transfer is dropped; the requester re-presents it.
- Pointer wrap: when last_grant = NUM_REQ-1, the search starts at index 0.

Test Plan:
- Single requester (req2 write, addr=0x10, wdata=0xA5A5A5A5, s_ready tied 1) -> s_valid, s_we=1, s_addr=0x10 in cycle 1; m_ready=4'b0100 same cycle; IDLE in cycle 2.
- All four m_valid held high, zero-wait target -> grant order 0,1,2,3,0,1; one m_ready pulse every 2 cycles; never two m_ready bits high at once.
- Read from req1 with target waiting 3 cycles, then s_ready=1 with s_rdata=0xDEADBEEF -> s_valid held 4 cycles; m_ready[1] high only in the last cycle; m_rdata=0xDEADBEEF that cycle.
- Req3 granted and waiting; req0 asserts mid-grant -> req0 not granted until after req3 completes; next grant is 0 (wrap from last_grant=3).
- Assert rst during GRANT with s_ready=0 -> s_valid=0 and m_ready=0 immediately (asynchronous); after release with req1 and req0 valid, the first grant is 0.
- Granted req2 drops m_valid before s_ready -> return to IDLE with no m_ready pulse; last_grant unchanged, so req2 is re-eligible at priority.
